// File: rtl/tt_dfd_vidtopid_mapper.sv
// VID->PID translation table for the debug fabric, filled one hart per cycle by a scan FSM.
// Define TT_DFD_VIDTOPID_REVERSE_EN to add the reverse (PID->VID) lookup path.
module tt_dfd_vidtopid_mapper #(
    parameter int NumHarts    = 8,
    parameter int NumHartsIdx = (NumHarts == 1) ? 1 : $clog2(NumHarts),
    parameter int NumLookups  = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NumHarts-1:0]                    fuse_map,
    input  logic [NumHarts-1:0][NumHartsIdx-1:0]   vid_map,
    input  logic                                   rebuild_req,
    input  logic [NumLookups-1:0]                  lkp_vld,
    input  logic [NumLookups-1:0][NumHartsIdx-1:0] lkp_vid,
    output logic [NumLookups-1:0]                  lkp_rdy,
    output logic [NumLookups-1:0]                  rsp_vld,
    output logic [NumLookups-1:0][NumHartsIdx-1:0] rsp_pid,
    output logic [NumLookups-1:0]                  rsp_mapped,
`ifdef TT_DFD_VIDTOPID_REVERSE_EN
    input  logic [NumLookups-1:0]                  rlkp_vld,
    input  logic [NumLookups-1:0][NumHartsIdx-1:0] rlkp_pid,
    output logic [NumLookups-1:0]                  rrsp_vld,
    output logic [NumLookups-1:0][NumHartsIdx-1:0] rrsp_vid,
    output logic [NumLookups-1:0]                  rrsp_mapped,
`endif
    input  logic [NumHarts-1:0]                    vid_vector,
    output logic [NumHarts-1:0]                    pid_vector,
    output logic                                   table_valid,
    output logic                                   dup_err
);

    typedef enum logic {ST_SCAN, ST_READY} state_e;

    localparam logic [NumHartsIdx-1:0] LastIdx = NumHartsIdx'(NumHarts - 1);

    state_e                                 state_q, state_d;
    logic [NumHartsIdx-1:0]                 idx_q, idx_d;
    logic [NumHarts-1:0][NumHartsIdx-1:0]   pid_q, pid_d;
    logic [NumHarts-1:0]                    mapped_q, mapped_d;
    logic                                   dup_q, dup_d;
    logic [NumLookups-1:0]                  rsp_vld_q, rsp_vld_d;
    logic [NumLookups-1:0][NumHartsIdx-1:0] rsp_pid_q, rsp_pid_d;
    logic [NumLookups-1:0]                  rsp_mapped_q, rsp_mapped_d;
    logic [NumHarts-1:0]                    pid_vec_q, pid_vec_d;
    logic                                   scan_wr;
    logic [NumHartsIdx-1:0]                 scan_vid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SCAN;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // A rebuild request in either state restarts the scan from hart 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_SCAN: begin
                if (rebuild_req) begin
                    idx_d = '0;
                end else if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = ST_READY;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_READY: begin
                if (rebuild_req) begin
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_SCAN;
            end
        endcase
    end

    always_comb begin
        table_valid = (state_q == ST_READY);
        lkp_rdy     = {NumLookups{table_valid & ~rebuild_req}};
    end

    assign scan_wr  = (state_q == ST_SCAN) && fuse_map[idx_q];
    assign scan_vid = vid_map[idx_q];

    // Later (higher index) harts overwrite earlier ones; a collision marks dup_err.
    always_comb begin
        pid_d    = pid_q;
        mapped_d = mapped_q;
        dup_d    = dup_q;
        if (rebuild_req) begin
            pid_d    = '0;
            mapped_d = '0;
            dup_d    = 1'b0;
        end else if (scan_wr) begin
            if (mapped_q[scan_vid]) begin
                dup_d = 1'b1;
            end
            pid_d[scan_vid]    = idx_q;
            mapped_d[scan_vid] = 1'b1;
        end
    end

    always_comb begin
        rsp_vld_d    = '0;
        rsp_pid_d    = rsp_pid_q;
        rsp_mapped_d = rsp_mapped_q;
        for (int c = 0; c < NumLookups; c++) begin
            if (lkp_vld[c] && lkp_rdy[c]) begin
                rsp_vld_d[c]    = 1'b1;
                rsp_pid_d[c]    = pid_q[lkp_vid[c]];
                rsp_mapped_d[c] = mapped_q[lkp_vid[c]];
            end
        end
    end

    // The vector view is suppressed while the table is being rebuilt.
    always_comb begin
        pid_vec_d = '0;
        if ((state_q == ST_READY) && !rebuild_req) begin
            for (int k = 0; k < NumHarts; k++) begin
                if (mapped_q[k]) begin
                    pid_vec_d[pid_q[k]] = vid_vector[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pid_q        <= '0;
            mapped_q     <= '0;
            dup_q        <= 1'b0;
            rsp_vld_q    <= '0;
            rsp_pid_q    <= '0;
            rsp_mapped_q <= '0;
            pid_vec_q    <= '0;
        end else begin
            pid_q        <= pid_d;
            mapped_q     <= mapped_d;
            dup_q        <= dup_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_pid_q    <= rsp_pid_d;
            rsp_mapped_q <= rsp_mapped_d;
            pid_vec_q    <= pid_vec_d;
        end
    end

    assign rsp_vld    = rsp_vld_q;
    assign rsp_pid    = rsp_pid_q;
    assign rsp_mapped = rsp_mapped_q;
    assign pid_vector = pid_vec_q;
    assign dup_err    = dup_q;

`ifdef TT_DFD_VIDTOPID_REVERSE_EN
    logic [NumHarts-1:0][NumHartsIdx-1:0]   rvid_q, rvid_d;
    logic [NumHarts-1:0]                    rmapped_q, rmapped_d;
    logic [NumLookups-1:0]                  rrsp_vld_q, rrsp_vld_d;
    logic [NumLookups-1:0][NumHartsIdx-1:0] rrsp_vid_q, rrsp_vid_d;
    logic [NumLookups-1:0]                  rrsp_mapped_q, rrsp_mapped_d;

    // Reverse table is indexed by physical hart, so each scan step writes its own slot.
    always_comb begin
        rvid_d        = rvid_q;
        rmapped_d     = rmapped_q;
        rrsp_vld_d    = '0;
        rrsp_vid_d    = rrsp_vid_q;
        rrsp_mapped_d = rrsp_mapped_q;
        if (rebuild_req) begin
            rvid_d    = '0;
            rmapped_d = '0;
        end else if (scan_wr) begin
            rvid_d[idx_q]    = scan_vid;
            rmapped_d[idx_q] = 1'b1;
        end
        for (int c = 0; c < NumLookups; c++) begin
            if (rlkp_vld[c] && lkp_rdy[c]) begin
                rrsp_vld_d[c]    = 1'b1;
                rrsp_vid_d[c]    = rvid_q[rlkp_pid[c]];
                rrsp_mapped_d[c] = rmapped_q[rlkp_pid[c]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvid_q        <= '0;
            rmapped_q     <= '0;
            rrsp_vld_q    <= '0;
            rrsp_vid_q    <= '0;
            rrsp_mapped_q <= '0;
        end else begin
            rvid_q        <= rvid_d;
            rmapped_q     <= rmapped_d;
            rrsp_vld_q    <= rrsp_vld_d;
            rrsp_vid_q    <= rrsp_vid_d;
            rrsp_mapped_q <= rrsp_mapped_d;
        end
    end

    assign rrsp_vld    = rrsp_vld_q;
    assign rrsp_vid    = rrsp_vid_q;
    assign rrsp_mapped = rrsp_mapped_q;
`endif

endmodule

// File: tb/tb_tt_dfd_vidtopid_mapper.sv
// Self-checking bench for tt_dfd_vidtopid_mapper: scoreboard of expected lookup
// responses plus a reference table rebuilt from the fuse/VID maps.
module tb_tt_dfd_vidtopid_mapper;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       fuse_map;
    logic [7:0][2:0]  vid_map;
    logic             rebuild_req;
    logic [1:0]       lkp_vld;
    logic [1:0][2:0]  lkp_vid;
    logic [1:0]       lkp_rdy;
    logic [1:0]       rsp_vld;
    logic [1:0][2:0]  rsp_pid;
    logic [1:0]       rsp_mapped;
    logic [7:0]       vid_vector;
    logic [7:0]       pid_vector;
    logic             table_valid;
    logic             dup_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         ch;
        logic [2:0] pid;
        logic       mapped;
    } exp_t;

    exp_t sbq[$];

    logic [2:0] m_pid [8];
    logic       m_map [8];
    logic       m_dup;

    tt_dfd_vidtopid_mapper #(.NumHarts(8), .NumLookups(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fuse_map    (fuse_map),
        .vid_map     (vid_map),
        .rebuild_req (rebuild_req),
        .lkp_vld     (lkp_vld),
        .lkp_vid     (lkp_vid),
        .lkp_rdy     (lkp_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_pid     (rsp_pid),
        .rsp_mapped  (rsp_mapped),
        .vid_vector  (vid_vector),
        .pid_vector  (pid_vector),
        .table_valid (table_valid),
        .dup_err     (dup_err)
    );

    always #5 clk = ~clk;

    // Reference table: present harts in ascending order, later ones overwrite.
    function automatic void build_model();
        m_dup = 1'b0;
        for (int v = 0; v < 8; v++) begin
            m_pid[v] = 3'd0;
            m_map[v] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if (fuse_map[i]) begin
                if (m_map[vid_map[i]]) m_dup = 1'b1;
                m_pid[vid_map[i]] = 3'(i);
                m_map[vid_map[i]] = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] model_pvec(input logic [7:0] vec);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (m_map[k]) r[m_pid[k]] = vec[k];
        end
        return r;
    endfunction

    function automatic void set_map_reversed();
        fuse_map = 8'hFF;
        for (int i = 0; i < 8; i++) vid_map[i] = 3'(7 - i);
    endfunction

    function automatic void set_map_identity(input logic [7:0] fuses);
        fuse_map = fuses;
        for (int i = 0; i < 8; i++) vid_map[i] = 3'(i);
    endfunction

    // Drive one lookup cycle and record the responses it must produce.
    task automatic drive_lookup(input logic [1:0] vld, input logic [2:0] v0, input logic [2:0] v1);
        exp_t e;
        lkp_vld    = vld;
        lkp_vid[0] = v0;
        lkp_vid[1] = v1;
        for (int c = 0; c < 2; c++) begin
            if (vld[c]) begin
                e.ch     = c;
                e.pid    = m_map[lkp_vid[c]] ? m_pid[lkp_vid[c]] : 3'd0;
                e.mapped = m_map[lkp_vid[c]];
                sbq.push_back(e);
            end
        end
    endtask

    // Pulse rebuild_req and count cycles until the table is valid again (0 if timed out).
    task automatic do_rebuild(output int cycles);
        rebuild_req = 1'b1;
        @(negedge clk);
        rebuild_req = 1'b0;
        cycles = 1;
        while (!table_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (!table_valid) cycles = 0;
    endtask

    task automatic test_reset();
        int cycles;
        reset_n     = 1'b0;
        rebuild_req = 1'b0;
        lkp_vld     = 2'b00;
        lkp_vid     = '0;
        vid_vector  = 8'h00;
        set_map_reversed();
        build_model();
        @(negedge clk);
        n_cmp++;
        if ({table_valid, dup_err, lkp_rdy, rsp_vld, rsp_mapped, rsp_pid, pid_vector} !== 23'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got tv=%b dup=%b rdy=%b vld=%b pv=%h, want all 0",
                     table_valid, dup_err, lkp_rdy, rsp_vld, pid_vector);
        end
        reset_n = 1'b1;
        cycles  = 0;
        while (!table_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        n_cmp++;
        if (cycles != 8) begin
            n_bad++;
            $display("[TB] FAIL reset_scan_len: got %0d cycles, want 8", cycles);
        end
        n_cmp++;
        if (dup_err !== 1'b0 || lkp_rdy !== 2'b11) begin
            n_bad++;
            $display("[TB] FAIL ready_state: got dup=%b rdy=%b, want dup=0 rdy=11", dup_err, lkp_rdy);
        end
    endtask

    task automatic test_basic_lookup();
        exp_t e;
        drive_lookup(2'b01, 3'd2, 3'd0);
        @(negedge clk);
        lkp_vld = 2'b00;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (rsp_vld[e.ch] !== 1'b1 || rsp_pid[e.ch] !== e.pid || rsp_mapped[e.ch] !== e.mapped) begin
                n_bad++;
                $display("[TB] FAIL basic_lkp ch%0d: got vld=%b pid=%0d map=%b, want vld=1 pid=%0d map=%b",
                         e.ch, rsp_vld[e.ch], rsp_pid[e.ch], rsp_mapped[e.ch], e.pid, e.mapped);
            end
        end
        n_cmp++;
        if (rsp_pid[0] !== 3'd5) begin
            n_bad++;
            $display("[TB] FAIL basic_pid_const: got %0d, want 5", rsp_pid[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_vld !== 2'b00 || rsp_pid[0] !== 3'd5 || rsp_mapped[0] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL idle_hold: got vld=%b pid=%0d map=%b, want vld=00 pid=5 map=1",
                     rsp_vld, rsp_pid[0], rsp_mapped[0]);
        end
    endtask

    task automatic test_pid_vector();
        logic [7:0] vec;
        int         cycles;
        for (int t = 0; t < 4; t++) begin
            vec        = (t == 0) ? 8'h01 : 8'($urandom);
            vid_vector = vec;
            @(negedge clk);
            n_cmp++;
            if (pid_vector !== model_pvec(vec)) begin
                n_bad++;
                $display("[TB] FAIL pid_vec[%0d]: got %h, want %h (vid_vector %h)",
                         t, pid_vector, model_pvec(vec), vec);
            end
        end
        vid_vector  = 8'hFF;
        rebuild_req = 1'b1;
        #1;
        n_cmp++;
        if (lkp_rdy !== 2'b00) begin
            n_bad++;
            $display("[TB] FAIL rdy_during_rebuild: got %b, want 00", lkp_rdy);
        end
        @(negedge clk);
        rebuild_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (pid_vector !== 8'h00 || table_valid !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL scan_pvec[%0d]: got pv=%h tv=%b, want pv=00 tv=0", k, pid_vector, table_valid);
            end
            @(negedge clk);
        end
        cycles = 0;
        while (!table_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        n_cmp++;
        if (table_valid !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL pvec_rebuild_done: got tv=%b, want 1", table_valid);
        end
        vid_vector = 8'h00;
    endtask

    task automatic test_unfused();
        exp_t e;
        int   cycles;
        set_map_identity(8'hFE);
        build_model();
        do_rebuild(cycles);
        n_cmp++;
        if (cycles != 9) begin
            n_bad++;
            $display("[TB] FAIL unfused_scan_len: got %0d, want 9", cycles);
        end
        drive_lookup(2'b11, 3'd0, 3'd3);
        @(negedge clk);
        lkp_vld = 2'b00;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (rsp_vld[e.ch] !== 1'b1 || rsp_pid[e.ch] !== e.pid || rsp_mapped[e.ch] !== e.mapped) begin
                n_bad++;
                $display("[TB] FAIL unfused_lkp ch%0d: got vld=%b pid=%0d map=%b, want vld=1 pid=%0d map=%b",
                         e.ch, rsp_vld[e.ch], rsp_pid[e.ch], rsp_mapped[e.ch], e.pid, e.mapped);
            end
        end
        n_cmp++;
        if (dup_err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL unfused_dup: got %b, want 0", dup_err);
        end
    endtask

    task automatic test_duplicate();
        exp_t e;
        int   cycles;
        set_map_identity(8'hFF);
        vid_map[6] = 3'd4;
        build_model();
        do_rebuild(cycles);
        n_cmp++;
        if (dup_err !== 1'b1 || m_dup !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL dup_set: got %b, want 1", dup_err);
        end
        drive_lookup(2'b11, 3'd4, 3'd6);
        @(negedge clk);
        lkp_vld = 2'b00;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (rsp_vld[e.ch] !== 1'b1 || rsp_pid[e.ch] !== e.pid || rsp_mapped[e.ch] !== e.mapped) begin
                n_bad++;
                $display("[TB] FAIL dup_lkp ch%0d: got vld=%b pid=%0d map=%b, want vld=1 pid=%0d map=%b",
                         e.ch, rsp_vld[e.ch], rsp_pid[e.ch], rsp_mapped[e.ch], e.pid, e.mapped);
            end
        end
        n_cmp++;
        if (rsp_pid[0] !== 3'd6 || dup_err !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL dup_winner: got pid=%0d dup=%b, want pid=6 dup=1", rsp_pid[0], dup_err);
        end
        set_map_identity(8'hFF);
        build_model();
        do_rebuild(cycles);
        n_cmp++;
        if (dup_err !== 1'b0 || cycles != 9) begin
            n_bad++;
            $display("[TB] FAIL dup_clear: got dup=%b cycles=%0d, want dup=0 cycles=9", dup_err, cycles);
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        int         cycles;
        logic [1:0] exp_vld;
        logic [1:0] vld;
        set_map_reversed();
        build_model();
        do_rebuild(cycles);
        drive_lookup(2'b11, 3'd2, 3'd7);
        @(negedge clk);
        lkp_vld = 2'b00;
        n_cmp++;
        if (rsp_vld !== 2'b11 || rsp_pid[0] !== 3'd5 || rsp_pid[1] !== 3'd0) begin
            n_bad++;
            $display("[TB] FAIL dual_const: got vld=%b pid0=%0d pid1=%0d, want vld=11 pid0=5 pid1=0",
                     rsp_vld, rsp_pid[0], rsp_pid[1]);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (rsp_vld[e.ch] !== 1'b1 || rsp_pid[e.ch] !== e.pid || rsp_mapped[e.ch] !== e.mapped) begin
                n_bad++;
                $display("[TB] FAIL dual_lkp ch%0d: got vld=%b pid=%0d map=%b, want vld=1 pid=%0d map=%b",
                         e.ch, rsp_vld[e.ch], rsp_pid[e.ch], rsp_mapped[e.ch], e.pid, e.mapped);
            end
        end
        // A mix of fuses and VIDs gives both mapped and unmapped responses.
        fuse_map = 8'b1011_0110;
        for (int i = 0; i < 8; i++) vid_map[i] = 3'((i * 3 + 1) % 8);
        build_model();
        do_rebuild(cycles);
        for (int t = 0; t < 20; t++) begin
            vld = 2'($urandom_range(0, 3));
            drive_lookup(vld, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            exp_vld = vld;
            @(negedge clk);
            n_cmp++;
            if (rsp_vld !== exp_vld) begin
                n_bad++;
                $display("[TB] FAIL b2b_vld[%0d]: got %b, want %b", t, rsp_vld, exp_vld);
            end
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp++;
                if (rsp_vld[e.ch] !== 1'b1 || rsp_pid[e.ch] !== e.pid || rsp_mapped[e.ch] !== e.mapped) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_lkp[%0d] ch%0d: got vld=%b pid=%0d map=%b, want vld=1 pid=%0d map=%b",
                             t, e.ch, rsp_vld[e.ch], rsp_pid[e.ch], rsp_mapped[e.ch], e.pid, e.mapped);
                end
            end
        end
        lkp_vld = 2'b00;
    endtask

    task automatic test_rebuild_mid_scan();
        exp_t e;
        int   cycles;
        set_map_reversed();
        build_model();
        do_rebuild(cycles);
        // Lookup accepted just before a rebuild still answers from the old table.
        drive_lookup(2'b01, 3'd2, 3'd0);
        @(negedge clk);
        lkp_vld = 2'b00;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (rsp_vld[e.ch] !== 1'b1 || rsp_pid[e.ch] !== e.pid || rsp_mapped[e.ch] !== e.mapped) begin
                n_bad++;
                $display("[TB] FAIL pre_rebuild_lkp ch%0d: got vld=%b pid=%0d map=%b, want vld=1 pid=%0d map=%b",
                         e.ch, rsp_vld[e.ch], rsp_pid[e.ch], rsp_mapped[e.ch], e.pid, e.mapped);
            end
        end
        set_map_identity(8'hFF);
        build_model();
        rebuild_req = 1'b1;
        @(negedge clk);
        rebuild_req = 1'b0;
        repeat (5) @(negedge clk);
        do_rebuild(cycles);
        n_cmp++;
        if (cycles != 9) begin
            n_bad++;
            $display("[TB] FAIL restart_scan_len: got %0d, want 9", cycles);
        end
        drive_lookup(2'b10, 3'd0, 3'd3);
        vid_vector = 8'hFF;
        @(negedge clk);
        lkp_vld = 2'b00;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (rsp_vld[e.ch] !== 1'b1 || rsp_pid[e.ch] !== e.pid || rsp_mapped[e.ch] !== e.mapped) begin
                n_bad++;
                $display("[TB] FAIL restart_lkp ch%0d: got vld=%b pid=%0d map=%b, want vld=1 pid=%0d map=%b",
                         e.ch, rsp_vld[e.ch], rsp_pid[e.ch], rsp_mapped[e.ch], e.pid, e.mapped);
            end
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({table_valid, dup_err, lkp_rdy, rsp_vld, rsp_mapped, rsp_pid, pid_vector} !== 23'd0) begin
            n_bad++;
            $display("[TB] FAIL async_reset: got tv=%b rdy=%b vld=%b map=%b pid=%h pv=%h, want all 0",
                     table_valid, lkp_rdy, rsp_vld, rsp_mapped, rsp_pid, pid_vector);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        vid_vector = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic_lookup();
        test_pid_vector();
        test_unfused();
        test_duplicate();
        test_back_to_back();
        test_rebuild_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
